// File: rtl/mem_rd_pkg.sv
// Shared definitions for the memory burst reader.
//   state_e    : burst FSM states
//   DEF_*      : default widths and sizing used as parameter defaults
//   credit_w() : width of a counter that must hold 0..depth inclusive
package mem_rd_pkg;

  localparam int DEF_AW         = 32;
  localparam int DEF_DW         = 32;
  localparam int DEF_LW         = 16;
  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of the credit/occupancy counters for the default FIFO depth.
  localparam int CREDIT_W = credit_w(DEF_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mem_burst_reader_if.sv
// Bundle of the burst reader's request, memory-read and output-stream signals.
//   slave  : the reader itself (accepts requests, drives the memory address
//            and the output stream)
//   master : the surrounding system (issues requests, returns memory data,
//            consumes the output stream)
interface mem_burst_reader_if
  import mem_rd_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW
) ();

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [AW-1:0] mem_rdaddr;
  logic [DW-1:0] mem_q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  modport slave (
    input  req_valid, req_addr, req_len, mem_q, out_ready,
    output req_ready, mem_rdaddr, out_valid, out_data, out_last, busy, done
  );

  modport master (
    output req_valid, req_addr, req_len, mem_q, out_ready,
    input  req_ready, mem_rdaddr, out_valid, out_data, out_last, busy, done
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push, din  : write strobe and data; ignored when full unless popping too
//   pop        : consume the head entry; ignored when empty
//   dout       : head entry, valid whenever empty is low
//   empty      : no entries held
//   count      : current occupancy, 0..DEPTH
// Push and pop in the same cycle are legal at any occupancy, including full.
module sync_fifo_fwft
  import mem_rd_pkg::*;
#(
  parameter int WIDTH = DEF_DW + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count, so
  // stale contents are never observed and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read engine for a memory with a registered read path.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any burst)
//   bus        : request (req_*), memory read port (mem_rdaddr/mem_q),
//                output stream (out_*), status (busy, done)
// A request (addr, len) issues len sequential read addresses. A shift pipe of
// RD_LATENCY stages tracks which cycles carry returning data; returned words
// land in an output FIFO. Reads are only issued while FIFO occupancy plus
// words in flight is below FIFO_DEPTH, so the FIFO can never overflow.
module mem_burst_reader
  import mem_rd_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int LW         = DEF_LW,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_burst_reader_if.slave  bus
);

  localparam int CW = credit_w(FIFO_DEPTH);

  state_e                state_q;
  state_e                state_d;
  logic [AW-1:0]         cur_addr;
  logic [AW-1:0]         rdaddr_q;
  logic [LW-1:0]         remaining;
  logic [RD_LATENCY-1:0] pipe_v;
  logic [RD_LATENCY-1:0] pipe_l;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic                  busy_q;
  logic                  done_q;
  logic                  accept;
  logic                  issue;
  logic                  finish;
  logic                  credit_ok;
  logic                  tail_v;
  logic                  tail_l;
  logic                  pop;
  logic                  empty;
  logic [DW:0]           fifo_dout;

  assign tail_v = pipe_v[RD_LATENCY-1];
  assign tail_l = pipe_l[RD_LATENCY-1];
  assign pop    = !empty && bus.out_ready;

  // Pops in the current cycle are deliberately not credited: simpler timing,
  // and FIFO_DEPTH >= RD_LATENCY+2 still sustains one word per cycle.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        accept = bus.req_valid;
        if (bus.req_valid && (bus.req_len != '0)) state_d = ISSUE;
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_dout[0]) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
      rdaddr_q  <= '0;
      pipe_v    <= '0;
      pipe_l    <= '0;
      inflight  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr  <= bus.req_addr;
        remaining <= bus.req_len;
      end else if (issue) begin
        rdaddr_q  <= cur_addr;
        cur_addr  <= cur_addr + AW'(1);   // wraps naturally at 2^AW
        remaining <= remaining - LW'(1);
      end
      // Stage 0 is the cycle the address is registered; the tail stage marks
      // the cycle in which mem_q holds that address's data.
      pipe_v   <= (pipe_v << 1) | RD_LATENCY'(issue);
      pipe_l   <= (pipe_l << 1) | RD_LATENCY'(issue && (remaining == LW'(1)));
      inflight <= inflight + CW'(issue) - CW'(tail_v);
      if (accept && (bus.req_len != '0)) busy_q <= 1'b1;
      else if (finish)                   busy_q <= 1'b0;
      done_q <= (accept && (bus.req_len == '0)) || finish;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tail_v),
    .din   ({bus.mem_q, tail_l}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (empty),
    .count (fifo_count)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_rdaddr = rdaddr_q;
  assign bus.out_valid  = !empty;
  // Gated so data/last read as zero while nothing is held (e.g. after reset).
  assign bus.out_data   = empty ? '0 : fifo_dout[DW:1];
  assign bus.out_last   = !empty && fifo_dout[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
`timescale 1ns/1ps
module tb_mem_burst_reader;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_burst_reader_if #(.AW(32), .DW(32), .LW(16)) bus ();
  mem_burst_reader_if #(.AW(4),  .DW(32), .LW(16)) bus4 ();

  mem_burst_reader #(.AW(32), .DW(32), .LW(16), .RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  mem_burst_reader #(.AW(4), .DW(32), .LW(16), .RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  // Memory: data register behind the reader's registered address, mem[i]=i*3.
  always @(posedge clk) bus.mem_q  <= bus.mem_rdaddr * 32'd3;
  always @(posedge clk) bus4.mem_q <= {28'd0, bus4.mem_rdaddr} * 32'd3;

  int total = 0;
  int bad   = 0;
  beat_t exp_q[$];
  beat_t exp4_q[$];
  beat_t e1;
  beat_t e4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{data: (addr + 32'(i)) * 32'd3, last: (i == len - 1)});
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [15:0] len);
    int n = 0;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 0, 1);
    tick(1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!bus.done && n < limit) begin
      tick(1);
      n++;
    end
    check("done_seen", bus.done, 1);
  endtask

  // Monitor / scoreboard for the main instance.
  int          beat_cnt = 0;
  int          last_cnt = 0;
  int          done_cnt = 0;
  int          max_occ  = 0;
  logic        prev_stall = 1'b0;
  logic        exp_done   = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (exp_done) check("done_after_last", bus.done, 1);
      if (bus.done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
        check("hold_last", bus.out_last, prev_last);
      end
      if (int'(u_dut.fifo_count) > max_occ) max_occ = int'(u_dut.fifo_count);
      exp_done = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e1 = exp_q.pop_front();
          check("beat_data", bus.out_data, e1.data);
          check("beat_last", bus.out_last, e1.last);
        end
        if (bus.out_last) begin
          last_cnt++;
          exp_done = 1'b1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  // Monitor for the narrow-address instance.
  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (exp4_q.size() == 0) check("w_unexpected_beat", 1, 0);
      else begin
        e4 = exp4_q.pop_front();
        check("w_beat_data", bus4.out_data, e4.data);
        check("w_beat_last", bus4.out_last, e4.last);
      end
    end
  end

  // Random backpressure driver.
  logic rand_en = 1'b0;
  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  int b0;
  int l0;
  int d0;
  int n;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.out_ready  = 1'b1;
    bus4.req_valid = 1'b0;
    bus4.req_addr  = '0;
    bus4.req_len   = '0;
    bus4.out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_rdaddr", bus.mem_rdaddr, 0);
    check("rst_req_ready", bus.req_ready, 1);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Basic burst: addr=5 len=4, accept edge A
    push_exp(32'd5, 4);
    do_req(32'd5, 16'd4);
    check("t1_busy", bus.busy, 1);
    tick(1);
    check("t1_first_addr", bus.mem_rdaddr, 5);
    tick(1);
    check("t1_not_yet_valid", bus.out_valid, 0);
    tick(1);
    check("t1_first_valid", bus.out_valid, 1);
    check("t1_first_data", bus.out_data, 15);
    tick(4);
    check("t1_done", bus.done, 1);
    check("t1_busy_clear", bus.busy, 0);
    check("t1_req_ready", bus.req_ready, 1);
    tick(1);
    check("t1_done_pulse", bus.done, 0);
    check("t1_drained", exp_q.size(), 0);

    // Zero-length request
    do_req(32'd7, 16'd0);
    check("t2_done", bus.done, 1);
    check("t2_busy", bus.busy, 0);
    check("t2_req_ready", bus.req_ready, 1);
    check("t2_addr_hold", bus.mem_rdaddr, 8);
    tick(1);
    check("t2_done_pulse", bus.done, 0);
    tick(3);
    check("t2_no_valid", bus.out_valid, 0);
    check("t2_addr_hold2", bus.mem_rdaddr, 8);

    // Backpressure: out_ready low for cycles 3..12 after accept
    push_exp(32'd0, 16);
    do_req(32'd0, 16'd16);
    tick(2);
    bus.out_ready = 1'b0;
    tick(10);
    check("t3_fifo_full", u_dut.fifo_count, 4);
    check("t3_issue_stalled", bus.mem_rdaddr, 3);
    bus.out_ready = 1'b1;
    wait_done(100);
    check("t3_drained", exp_q.size(), 0);

    // Address wrap on the 4-bit instance
    for (int i = 0; i < 4; i++)
      exp4_q.push_back('{data: 32'((14 + i) % 16) * 32'd3, last: (i == 3)});
    bus4.req_addr  = 4'd14;
    bus4.req_len   = 16'd4;
    bus4.req_valid = 1'b1;
    tick(1);
    bus4.req_valid = 1'b0;
    tick(1);
    check("t4_addr0", bus4.mem_rdaddr, 14);
    tick(1);
    check("t4_addr1", bus4.mem_rdaddr, 15);
    tick(1);
    check("t4_addr2", bus4.mem_rdaddr, 0);
    tick(1);
    check("t4_addr3", bus4.mem_rdaddr, 1);
    tick(10);
    check("t4_drained", exp4_q.size(), 0);
    check("t4_idle", bus4.busy, 0);

    // Random backpressure over 100 words
    b0 = beat_cnt;
    l0 = last_cnt;
    push_exp(32'd100, 100);
    do_req(32'd100, 16'd100);
    rand_en = 1'b1;
    wait_done(2000);
    rand_en = 1'b0;
    tick(1);
    bus.out_ready = 1'b1;
    check("t5_beats", beat_cnt - b0, 100);
    check("t5_one_last", last_cnt - l0, 1);
    check("t5_drained", exp_q.size(), 0);

    // Reset in the middle of a burst
    b0 = beat_cnt;
    push_exp(32'd30, 10);
    do_req(32'd30, 16'd10);
    n = 0;
    while (beat_cnt < b0 + 3 && n < 50) begin
      tick(1);
      n++;
    end
    check("t6_reached_beat3", beat_cnt >= b0 + 3, 1);
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_out_last", bus.out_last, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done, 0);
    check("t6_mem_rdaddr", bus.mem_rdaddr, 0);
    check("t6_req_ready", bus.req_ready, 1);
    exp_q.delete();
    d0 = done_cnt;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("t6_no_done", done_cnt, d0);
    check("t6_no_valid", bus.out_valid, 0);
    push_exp(32'd20, 2);
    do_req(32'd20, 16'd2);
    wait_done(50);
    tick(1);
    check("t6_drained", exp_q.size(), 0);

    // Whole-run properties
    check("done_count", done_cnt, 5);
    check("max_occupancy_le_depth", max_occ <= 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side engine for a dual-port memory with a registered read address and registered read data (read latency 2 clk).
- Accepts a burst request (start address, word count) and issues sequential read addresses.
- Captures the returned words, tracking memory latency, and streams them out on a valid/ready interface with full backpressure.
- Output buffering uses a credit-limited FIFO. Sits between the memory read port and downstream consumers, in the memory's read clock domain.

Parameters:
AW, 32, address width; also width of mem_rdaddr and req_addr
DW, 32, data word width
LW, 16, burst length field width; max burst 2^LW-1 words
RD_LATENCY, 2, clk cycles from mem_rdaddr driven to mem_q valid; legal range 1..4
FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LATENCY+2 for 1 word/cycle sustained

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  burst request valid
req_ready  out  1  high when a request can be accepted
req_addr  in  AW  first word address
req_len  in  LW  number of words; 0 is legal
mem_rdaddr  out  AW  read address to memory
mem_q  in  DW  read data from memory, RD_LATENCY cycles after address
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts word
out_data  out  DW  output word
out_last  out  1  marks final word of burst
busy  out  1  high from request accept until burst complete
done  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, mem_rdaddr=0, out_valid=0, out_last=0, busy=0, done=0. Valid pipe, FIFO and counters are cleared. req_ready=1 once in IDLE.
- Reset asserted mid-burst aborts immediately: in-flight and buffered words are discarded, no done pulse.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready=(state==IDLE).
  - Handshake req_valid&req_ready with req_len>0: latch cur_addr=req_addr and remaining=req_len, go to ISSUE, busy=1 next cycle.
  - Handshake with req_len==0: stay IDLE, done pulses next cycle, no read issued, no output beat.
- ISSUE:
  - Issue allowed when credit = fifo_count + inflight < FIFO_DEPTH. A pop in the same cycle is not credited (conservative).
  - On issue: mem_rdaddr<=cur_addr; push (1, remaining==1) into an RD_LATENCY-deep valid/last shift pipe; cur_addr+1 mod 2^AW (wraps 2^AW-1 -> 0); remaining-1.
  - Issuing the word with remaining==1 moves the FSM to DRAIN.
  - Non-issue cycles push a 0 into the pipe; mem_rdaddr holds its value.
- Capture: when the pipe tail valid is 1, push {mem_q, last} into the FIFO. Credit guarantees the FIFO never overflows; the bench asserts this.
- FIFO: first-word-fall-through. out_valid = !empty; out_data/out_last come from the head entry. Pop on out_valid&out_ready. Simultaneous push and pop is legal at any occupancy, including full.
- DRAIN: no issues. When the beat with out_last=1 handshakes: next cycle done=1 for one cycle, busy=0, state IDLE. A new request may be accepted that same cycle.
- Latency:
  - First mem_rdaddr update occurs 1 cycle after request accept.
  - That word enters the FIFO RD_LATENCY cycles later; out_valid rises the cycle after that.
  - With out_ready held high: 1 word/clk sustained.
- out_ready low: issuing stalls once credit is exhausted. Words already in flight land in the FIFO; none are lost or duplicated.
- out_valid, once high, stays high with stable out_data/out_last until the handshake.

Decomposition:
- Package mem_rd_pkg: state enum (IDLE, ISSUE, DRAIN), default width constants (AW, DW, LW), localparam for credit counter width $clog2(FIFO_DEPTH+1).
- One sub-module: sync_fifo_fwft, parameterised (WIDTH=DW+1, DEPTH), with its own asynchronous active-low reset and count output.

Test Plan:
- Memory model: 2-cycle registered read, mem[i]=i*3.
  - addr=5, len=4, out_ready=1 -> out_data 15,18,21,24 on consecutive cycles; out_last only on 24; done 1 cycle after the 24 handshake.
  - req_len=0 at addr=7 -> no mem_rdaddr change, no out_valid, done pulse next cycle, req_ready stays 1.
- Stalls and wrap:
  - addr=0, len=16, out_ready low for cycles 3-12 -> FIFO holds at most FIFO_DEPTH words, no overflow; all 16 words 0..45 in order after release.
  - AW=4, addr=14, len=4 -> mem_rdaddr 14,15,0,1; data 42,45,0,3.
- Random backpressure: out_ready random 50% over len=100 -> exactly 100 beats in order, one out_last, out_data stable while out_valid&!out_ready.
- Reset mid-burst: rst_n low at beat 3 of len=10 -> all outputs 0 immediately, no done. After release, a new request addr=20, len=2 returns 60,63.
